incubator_thermal_ctrl: RTL and testbench
=========================================

# incubator_thermal_ctrl

Parametrised next-generation incubator thermal controller: samples a signed temperature sensor, drives heater and cooler through a hysteretic IDLE/HEAT/COOL state machine, and sets a banded fan speed while cooling. It adds three things the fixed-threshold incubator lacks: a minimum-dwell anti-chatter counter, a sensor-valid qualifier, and a latched fail-safe FAULT state for out-of-range sensors. It sits between the sensor front end and the actuator drivers.

## Interface
Parameters:
- SW, 8: sensor width, signed two's complement.
- HEAT_ON, 15: enter HEAT when T < HEAT_ON.
- HEAT_OFF, 30: leave HEAT when T >= HEAT_OFF.
- COOL_ON, 35: enter COOL when T > COOL_ON.
- COOL_OFF, 25: leave COOL when T < COOL_OFF.
- FAN_BASE, 4: fan rps at band 0.
- FAN_STEP, 2: rps increment per band.
- FAN_BAND, 5: band width in degrees.
- DWELL, 4: minimum clocks in a state before a normal transition; must be >= 1.
- T_MIN, -20 / T_MAX, 70: valid sensor range, inclusive.
- FAULT_CYCLES, 16: consecutive out-of-range valid samples that trigger FAULT.
- Legal parameter sets satisfy HEAT_ON < HEAT_OFF < COOL_ON, HEAT_ON < COOL_OFF < COOL_ON, and all thresholds within T_MIN..T_MAX.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high.
- sensor, input, SW: signed temperature sample.
- sensor_valid, input, 1: sensor is sampled only on edges where this is 1.
- clear_fault, input, 1: request to leave FAULT.
- heater, output, 1: heater enable.
- cooler, output, 1: cooler enable.
- fan_rps, output, 4: fan speed command.
- state, output, 2: IDLE=0, HEAT=1, COOL=2, FAULT=3.
- fault, output, 1: high while in FAULT.

## Operation
- All outputs are registered. On reset, state=IDLE and heater, cooler, fan_rps, fault, the dwell counter and the fault counter are all 0.
- All comparisons are signed at SW+3 bits, so COOL_ON+3*FAN_BAND cannot overflow.
- Dwell counter: cleared on every state change, then increments each clk up to DWELL and saturates. A normal transition is allowed only when the counter equals DWELL.
- Fault counter: on each valid sample, cleared if T_MIN <= T <= T_MAX, otherwise incremented (saturating).
- IDLE: if T < HEAT_ON go to HEAT; if T > COOL_ON go to COOL.
- HEAT: if T > COOL_ON go directly to COOL; otherwise if T >= HEAT_OFF go to IDLE.
- COOL: if T < HEAT_ON go directly to HEAT; otherwise if T < COOL_OFF go to IDLE.
- FAULT entry: taken when the fault counter reaches FAULT_CYCLES on a valid sample, from any state. This ignores dwell and has priority over every other transition.
- FAULT exit: only on an edge with clear_fault=1, sensor_valid=1 and the sensor in range. Exit goes to IDLE. clear_fault outside FAULT is ignored.
- Output decode from the next state:
  - IDLE: heater=0, cooler=0, fan=0.
  - HEAT: heater=1, cooler=0, fan=0.
  - COOL: heater=0, cooler=1, fan per the banding rule below.
  - FAULT: heater=0, cooler=0, fan=15, fault=1.
- Fan banding in COOL: k = number of j in {1,2,3} with T >= COOL_ON + j*FAN_BAND. fan_rps = min(FAN_BASE + k*FAN_STEP, 15).
  - Recomputed on every valid sample, including samples below COOL_ON (which give k=0).
  - Held when sensor_valid=0.
- Edges with sensor_valid=0 cause no transition and no counter change, except that the dwell counter keeps counting.

## Timing
- A valid sample at edge N updates state and outputs after edge N; latency is 1 clock.
- After reset deasserts, the earliest transition is on the (DWELL+1)th rising edge.
- Reset asserted mid-operation clears all outputs immediately, without waiting for clk.
- With sensor_valid=1 held, the HEAT→IDLE→HEAT minimum period is 2*(DWELL+1) clocks.

## Test plan
- Reset, then sensor=-10 valid every cycle -> IDLE for 4 edges, HEAT (heater=1) on the 5th; at sensor=30, IDLE after the dwell has expired.
- Sweep sensor 20→55 one step per clock -> COOL once past 35; fan_rps=4 for 36..39, 6 at 40, 8 at 45, 10 at 50.
- Sweep 55→20 -> cooler stays 1 down to 25 and drops at 24; fan_rps follows the bands down to 4.
- In HEAT, sensor jumps 10→40 -> direct HEAT→COOL after dwell; no IDLE cycle.
- Sensor=100 for 16 valid samples -> FAULT with fan=15, heater=0, cooler=0.
  - Interleave sensor_valid=0 cycles -> count pauses; one in-range sample resets the count.
  - clear_fault with sensor=100 -> stays in FAULT.
  - clear_fault with sensor=20 -> IDLE.
- Assert reset asynchronously mid-COOL, between clock edges -> all outputs 0 and state=0 before the next edge.

Source files
------------

// File: rtl/incubator_thermal_ctrl.sv
// Incubator thermal controller: hysteretic IDLE/HEAT/COOL FSM with dwell, banded
// fan speed while cooling, and a latched FAULT for persistently out-of-range sensors.
module incubator_thermal_ctrl #(
    parameter int SW           = 8,
    parameter int HEAT_ON      = 15,
    parameter int HEAT_OFF     = 30,
    parameter int COOL_ON      = 35,
    parameter int COOL_OFF     = 25,
    parameter int FAN_BASE     = 4,
    parameter int FAN_STEP     = 2,
    parameter int FAN_BAND     = 5,
    parameter int DWELL        = 4,
    parameter int T_MIN        = -20,
    parameter int T_MAX        = 70,
    parameter int FAULT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [SW-1:0] sensor,
    input  logic                 sensor_valid,
    input  logic                 clear_fault,
    output logic                 heater,
    output logic                 cooler,
    output logic [3:0]           fan_rps,
    output logic [1:0]           state,
    output logic                 fault
);
    localparam int CW  = SW + 3;
    localparam int DWW = $clog2(DWELL + 1);
    localparam int FCW = $clog2(FAULT_CYCLES + 1);

    localparam logic signed [CW-1:0] HON  = CW'(HEAT_ON);
    localparam logic signed [CW-1:0] HOFF = CW'(HEAT_OFF);
    localparam logic signed [CW-1:0] CON  = CW'(COOL_ON);
    localparam logic signed [CW-1:0] COFF = CW'(COOL_OFF);
    localparam logic signed [CW-1:0] TLO  = CW'(T_MIN);
    localparam logic signed [CW-1:0] THI  = CW'(T_MAX);
    localparam logic signed [CW-1:0] B1   = CW'(COOL_ON + FAN_BAND);
    localparam logic signed [CW-1:0] B2   = CW'(COOL_ON + 2 * FAN_BAND);
    localparam logic signed [CW-1:0] B3   = CW'(COOL_ON + 3 * FAN_BAND);

    typedef enum logic [1:0] {IDLE = 2'd0, HEAT = 2'd1, COOL = 2'd2, FLT = 2'd3} st_t;

    st_t                     cur, nxt;
    logic [DWW-1:0]          dwell, dwell_d;
    logic [FCW-1:0]          fcnt, fcnt_d;
    logic signed [CW-1:0]    t;
    logic                    in_range, dwell_ok, fault_hit;
    logic [1:0]              k;
    logic [7:0]              fan_sum;
    logic [3:0]              fan_band, fan_d;
    logic                    heater_d, cooler_d, fault_d;

    assign t        = CW'(sensor);
    assign in_range = (t >= TLO) && (t <= THI);
    assign dwell_ok = (dwell == DWW'(DWELL));

    // Out-of-range counter only moves on valid samples; saturates at the trip point.
    always_comb begin
        fcnt_d = fcnt;
        if (sensor_valid) begin
            if (in_range)                           fcnt_d = '0;
            else if (fcnt != FCW'(FAULT_CYCLES))    fcnt_d = fcnt + 1'b1;
        end
    end
    assign fault_hit = sensor_valid && (fcnt_d == FCW'(FAULT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= IDLE;
        else       cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        if (fault_hit) begin
            nxt = FLT;
        end else if (sensor_valid) begin
            case (cur)
                IDLE: if (dwell_ok) begin
                    if (t < HON)      nxt = HEAT;
                    else if (t > CON) nxt = COOL;
                end
                HEAT: if (dwell_ok) begin
                    if (t > CON)       nxt = COOL;
                    else if (t >= HOFF) nxt = IDLE;
                end
                COOL: if (dwell_ok) begin
                    if (t < HON)       nxt = HEAT;
                    else if (t < COFF) nxt = IDLE;
                end
                FLT: if (clear_fault && in_range) nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        k        = 2'(t >= B1) + 2'(t >= B2) + 2'(t >= B3);
        fan_sum  = 8'(FAN_BASE) + 8'(k) * 8'(FAN_STEP);
        fan_band = (fan_sum > 8'd15) ? 4'd15 : fan_sum[3:0];
    end

    // Outputs decode from the next state; fan holds its value across invalid samples.
    always_comb begin
        heater_d = 1'b0;
        cooler_d = 1'b0;
        fault_d  = 1'b0;
        fan_d    = 4'd0;
        case (nxt)
            HEAT: heater_d = 1'b1;
            COOL: begin
                cooler_d = 1'b1;
                fan_d    = sensor_valid ? fan_band : fan_rps;
            end
            FLT: begin
                fault_d = 1'b1;
                fan_d   = 4'd15;
            end
            default: ;
        endcase
        if (nxt != cur)                dwell_d = '0;
        else if (dwell_ok)             dwell_d = dwell;
        else                           dwell_d = dwell + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            heater  <= 1'b0;
            cooler  <= 1'b0;
            fault   <= 1'b0;
            fan_rps <= 4'd0;
            dwell   <= '0;
            fcnt    <= '0;
        end else begin
            heater  <= heater_d;
            cooler  <= cooler_d;
            fault   <= fault_d;
            fan_rps <= fan_d;
            dwell   <= dwell_d;
            fcnt    <= fcnt_d;
        end
    end

    assign state = cur;
endmodule

// File: tb/tb_incubator_thermal_ctrl.sv
// Directed bench for incubator_thermal_ctrl with default parameters.
module tb_incubator_thermal_ctrl;
    logic              clk = 1'b0;
    logic              reset;
    logic signed [7:0] sensor;
    logic              sensor_valid;
    logic              clear_fault;
    logic              heater, cooler, fault;
    logic [3:0]        fan_rps;
    logic [1:0]        state;

    int n_tests = 0;
    int n_fail  = 0;

    incubator_thermal_ctrl dut (
        .clk(clk), .reset(reset), .sensor(sensor), .sensor_valid(sensor_valid),
        .clear_fault(clear_fault), .heater(heater), .cooler(cooler),
        .fan_rps(fan_rps), .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int st, input int h, input int c,
                           input int f, input int fl);
        chk({tag, ".state"},  int'(state),   st);
        chk({tag, ".heater"}, int'(heater),  h);
        chk({tag, ".cooler"}, int'(cooler),  c);
        chk({tag, ".fan"},    int'(fan_rps), f);
        chk({tag, ".fault"},  int'(fault),   fl);
    endtask

    // Called at a negedge: drive, take one rising edge, return at the next negedge.
    task automatic step(input int t, input logic v, input logic c);
        sensor       = t[7:0];
        sensor_valid = v;
        clear_fault  = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int cool_fan(input int t);
        if (t >= 50)      return 10;
        else if (t >= 45) return 8;
        else if (t >= 40) return 6;
        else              return 4;
    endfunction

    initial begin
        reset = 1'b1; sensor = '0; sensor_valid = 1'b0; clear_fault = 1'b0;
        @(negedge clk); @(negedge clk);
        chk_out("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Dwell after reset: first transition on the 5th edge.
        for (int i = 1; i <= 4; i++) begin
            step(-10, 1'b1, 1'b0);
            chk("dwell_idle.state", int'(state), 0);
        end
        step(-10, 1'b1, 1'b0);
        chk_out("heat_entry", 1, 1, 0, 0, 0);

        for (int i = 1; i <= 4; i++) begin
            step(30, 1'b1, 1'b0);
            chk("heat_hold.heater", int'(heater), 1);
        end
        step(30, 1'b1, 1'b0);
        chk_out("heat_exit", 0, 0, 0, 0, 0);

        // Upward sweep into COOL with fan banding.
        for (int t = 20; t <= 55; t++) begin
            step(t, 1'b1, 1'b0);
            if (t > 35) chk_out($sformatf("up%0d", t), 2, 0, 1, cool_fan(t), 0);
            else        chk_out($sformatf("up%0d", t), 0, 0, 0, 0, 0);
        end

        // Invalid sample: everything holds.
        step(20, 1'b0, 1'b0);
        chk_out("invalid_hold", 2, 0, 1, 10, 0);

        // Downward sweep: cooler holds to 25, drops at 24.
        for (int t = 54; t >= 20; t--) begin
            step(t, 1'b1, 1'b0);
            if (t >= 25) chk_out($sformatf("dn%0d", t), 2, 0, 1, cool_fan(t), 0);
            else         chk_out($sformatf("dn%0d", t), 0, 0, 0, 0, 0);
        end

        // Dwell already expired in IDLE: 10 goes straight to HEAT, then 40 goes direct to COOL.
        step(10, 1'b1, 1'b0);
        chk_out("heat2", 1, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step(40, 1'b1, 1'b0);
            chk("heat_to_cool_wait.state", int'(state), 1);
        end
        step(40, 1'b1, 1'b0);
        chk_out("heat_to_cool", 2, 0, 1, 6, 0);

        // Fault counter: pauses on invalid, resets on one in-range sample.
        for (int i = 0; i < 8; i++) step(100, 1'b1, 1'b0);
        step(100, 1'b0, 1'b0);
        step(100, 1'b0, 1'b0);
        step(40, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step(100, 1'b1, 1'b0);
        chk_out("pre_fault", 2, 0, 1, 10, 0);
        step(100, 1'b1, 1'b0);
        chk_out("fault_entry", 3, 0, 0, 15, 1);

        step(100, 1'b1, 1'b1);
        chk_out("clear_bad", 3, 0, 0, 15, 1);
        step(20, 1'b0, 1'b1);
        chk("clear_invalid.state", int'(state), 3);
        step(20, 1'b1, 1'b1);
        chk_out("clear_ok", 0, 0, 0, 0, 0);

        // Back into COOL, then asynchronous reset between edges.
        for (int i = 0; i < 5; i++) step(40, 1'b1, 1'b0);
        chk_out("cool_again", 2, 0, 1, 6, 0);
        #2 reset = 1'b1;
        #1 chk_out("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
